// File: rtl/float_pkg.sv
// Shared constants, operand classification and result packing for the
// single-precision multiplier.
package float_pkg;

  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned MANT_WIDTH = 23;
  localparam int unsigned EXP_BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_WAIT_LOW
  } state_e;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH:0]   mant;
    logic                  zero;
    logic                  inf;
    logic                  nan;
  } operand_t;

  // Denormals report as zero, so their mantissa is never looked at.
  function automatic operand_t unpack(input logic [31:0] f);
    operand_t o;
    o.sign = f[31];
    o.exp  = f[30:23];
    o.mant = {1'b1, f[22:0]};
    o.zero = (f[30:23] == '0);
    o.inf  = (f[30:23] == '1) && (f[22:0] == '0);
    o.nan  = (f[30:23] == '1) && (f[22:0] != '0);
    return o;
  endfunction

  function automatic logic [31:0] pack_result(input logic                 sign,
                                              input logic signed [9:0]    exp,
                                              input logic [MANT_WIDTH-1:0] mant,
                                              input logic                 nan,
                                              input logic                 inf,
                                              input logic                 zero);
    logic [31:0] r;
    if (nan)                    r = QNAN;
    else if (inf)               r = POS_INF | {sign, 31'b0};
    else if (zero)              r = {sign, 31'b0};
    else if (exp > 10'sd254)    r = POS_INF | {sign, 31'b0};
    else if (exp < 10'sd1)      r = {sign, 31'b0};
    else                        r = {sign, exp[7:0], mant};
    return r;
  endfunction

endpackage

// File: rtl/float_mul_datapath.sv
// Pipelined IEEE-754 single multiply: unpack, multiply, normalize; the packed
// result is combinational from stage 3 and registered by the caller.
module float_mul_datapath
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result
);

  logic                        s1_v_q;
  operand_t                    s1_a_q, s1_b_q;

  logic                        s2_v_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic signed [9:0]           s2_exp_q;
  logic [MANT_WIDTH+1:0]       s2_prod_q;

  logic                        s3_v_q, s3_sign_q, s3_nan_q, s3_inf_q, s3_zero_q;
  logic signed [9:0]           s3_exp_q;
  logic [MANT_WIDTH-1:0]       s3_mant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      s3_v_q    <= 1'b0;
      s3_sign_q <= 1'b0;
      s3_nan_q  <= 1'b0;
      s3_inf_q  <= 1'b0;
      s3_zero_q <= 1'b0;
      s3_exp_q  <= '0;
      s3_mant_q <= '0;
    end else begin
      s1_v_q <= in_valid;
      s1_a_q <= unpack(a);
      s1_b_q <= unpack(b);

      s2_v_q    <= s1_v_q;
      s2_sign_q <= s1_a_q.sign ^ s1_b_q.sign;
      s2_nan_q  <= s1_a_q.nan | s1_b_q.nan
                 | (s1_a_q.inf & s1_b_q.zero) | (s1_a_q.zero & s1_b_q.inf);
      s2_inf_q  <= s1_a_q.inf | s1_b_q.inf;
      s2_zero_q <= s1_a_q.zero | s1_b_q.zero;
      s2_exp_q  <= {2'b00, s1_a_q.exp} + {2'b00, s1_b_q.exp} - 10'(EXP_BIAS);
      // Only product bits [47:23] can reach the truncated mantissa.
      s2_prod_q <= 25'(({24'b0, s1_a_q.mant} * {24'b0, s1_b_q.mant}) >> 23);

      s3_v_q    <= s2_v_q;
      s3_sign_q <= s2_sign_q;
      s3_nan_q  <= s2_nan_q;
      s3_inf_q  <= s2_inf_q;
      s3_zero_q <= s2_zero_q;
      if (s2_prod_q[MANT_WIDTH+1]) begin
        s3_mant_q <= s2_prod_q[MANT_WIDTH:1];
        s3_exp_q  <= s2_exp_q + 10'sd1;
      end else begin
        s3_mant_q <= s2_prod_q[MANT_WIDTH-1:0];
        s3_exp_q  <= s2_exp_q;
      end
    end
  end

  assign out_valid = s3_v_q;
  assign result    = pack_result(s3_sign_q, s3_exp_q, s3_mant_q,
                                 s3_nan_q, s3_inf_q, s3_zero_q);

endmodule

// File: rtl/float_mul_pipeline.sv
// Single-precision multiplier with a one-request-at-a-time req/ack handshake;
// ack pulses four cycles after req is sampled and out holds until the next ack.
module float_mul_pipeline
  import float_pkg::*;
#(
  parameter int unsigned float_width = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ack,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic [float_width-1:0] out
);

  state_e                 state_q;
  logic                   ack_q;
  logic                   start_q;
  logic [float_width-1:0] out_q, a_q, b_q;
  logic                   dp_valid;
  logic [float_width-1:0] dp_result;

  float_mul_datapath u_datapath (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (start_q),
    .a         (a_q),
    .b         (b_q),
    .out_valid (dp_valid),
    .result    (dp_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      out_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            a_q     <= a;
            b_q     <= b;
            start_q <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dp_valid) begin
            out_q   <= dp_result;
            ack_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE:     state_q <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!req) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack = ack_q;
  assign out = out_q;

endmodule

// File: tb/tb_float_mul_pipeline.sv
// Directed-vector bench for float_mul_pipeline with hand-computed products.
module tb_float_mul_pipeline;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ack;
  logic [31:0] a, b, out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_out = '0;

  float_mul_pipeline #(.float_width(32)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .ack (ack),
    .a   (a),
    .b   (b),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one request held for 'hold' cycles; operands are scrambled right
  // after sampling to show they are captured at the request edge.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_v, input int hold, input string tag);
    int acks  = 0;
    int first = 0;
    @(negedge clk);
    a   = av;
    b   = bv;
    req = 1'b1;
    for (int k = 1; k <= hold + 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        a = $urandom;
        b = $urandom;
      end
      if (k == 4) check({tag, "/out_held"}, out, last_out);
      if (ack) begin
        acks++;
        if (first == 0) first = k;
      end
      if (k == hold) req = 1'b0;
    end
    check({tag, "/ack_count"}, 32'(acks), 32'd1);
    check({tag, "/ack_cycle"}, 32'(first), 32'd5);
    check({tag, "/out"}, out, exp_v);
    last_out = exp_v;
  endtask

  initial begin
    int acks;
    rst = 1'b0;
    req = 1'b0;
    a   = '0;
    b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/ack", 32'(ack), 32'd0);
    check("reset/out", out, 32'h0000_0000);
    @(negedge clk);
    rst  = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    check("idle/no_ack", 32'(acks), 32'd0);

    run_op(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 6, "0x1");
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 6, "1x0");
    run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6, "0x0");

    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6, "1x1");
    run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 6, "2x2");
    run_op(32'h4100_0000, 32'h4080_0000, 32'h4200_0000, 6, "8x4");
    run_op(32'h4130_0000, 32'h4130_0000, 32'h42F2_0000, 6, "11x11");
    run_op(32'h4348_0000, 32'h42C8_0000, 32'h469C_4000, 6, "200x100");

    run_op(32'h3F8C_CCCD, 32'h3F8C_CCCD, 32'h3F9A_E148, 6, "1.1x1.1");
    run_op(32'h3FF3_3333, 32'h3FF3_3333, 32'h4067_0A3D, 6, "1.9x1.9");
    run_op(32'h44FA_0000, 32'h4013_3333, 32'h458F_BFFF, 6, "2000x2.3");
    run_op(32'h4121_999A, 32'h4080_0000, 32'h4221_999A, 6, "10.1x4");

    run_op(32'hC4FA_0000, 32'h4013_3333, 32'hC58F_BFFF, 6, "-2000x2.3");
    run_op(32'h44FA_0000, 32'hC013_3333, 32'hC58F_BFFF, 6, "2000x-2.3");
    run_op(32'hC4FA_0000, 32'hC013_3333, 32'h458F_BFFF, 6, "-2000x-2.3");

    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 6, "nan");
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 6, "infx0");
    run_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 6, "infx-2");
    run_op(32'h7F00_0000, 32'h4080_0000, 32'h7F80_0000, 6, "overflow");
    run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 6, "underflow");
    run_op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 6, "-0x1");
    run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 6, "denorm");

    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 10, "hold10");
    run_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 6, "rereq");

    // Abort: reset while the operation is in flight.
    @(negedge clk);
    a   = 32'h4000_0000;
    b   = 32'h4000_0000;
    req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    acks = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    check("abort/no_ack", 32'(acks), 32'd0);
    check("abort/out", out, 32'h0000_0000);
    last_out = '0;

    run_op(32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, 6, "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
